// File: rtl/shared_reg_arbiter_pkg.sv
//==============================================================================
// Module   : shared_reg_pkg
// Brief    : Shared types and default sizing for the shared register arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package shared_reg_pkg;

    localparam int c_DEF_NUM_REQ   = 4;
    localparam int c_DEF_WIDTH     = 4;
    localparam int c_DEF_MAX_BURST = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shared_reg_arbiter_rr_pick.sv
//==============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request at or above
//            the start index, wrapping past the top.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (i_req[(int'(i_start) + off) % N]) begin
                w_found = 1'b1;
                w_idx   = IW'((int'(i_start) + off) % N);
            end
        end
    end

    assign o_found = w_found;
    assign o_idx   = w_idx;

endmodule

`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
//==============================================================================
// Module   : shared_reg_arbiter
// Brief    : Round-robin owner of a shared data register with bounded bursts.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NUM_REQ   = c_DEF_NUM_REQ,
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int MAX_BURST = c_DEF_MAX_BURST
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WIDTH-1:0]    wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic [WIDTH-1:0]            q,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy
);

    localparam int c_OW = $clog2(NUM_REQ);
    localparam int c_CW = $clog2(MAX_BURST + 1);
    localparam logic [c_OW-1:0] c_LAST_IDX = c_OW'(NUM_REQ - 1);
    localparam logic [c_CW-1:0] c_MAX_CNT  = c_CW'(MAX_BURST);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [WIDTH-1:0]    r_q;
    logic [c_OW-1:0]     r_owner;
    logic [c_CW-1:0]     r_cnt;
    logic [c_OW-1:0]     r_rr;

    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic [WIDTH-1:0]    w_q_nxt;
    logic [c_OW-1:0]     w_owner_nxt;
    logic [c_CW-1:0]     w_cnt_nxt;
    logic [c_OW-1:0]     w_rr_nxt;

    logic [c_OW-1:0]     w_owner_inc;
    logic [c_CW-1:0]     w_cnt_inc;
    logic [WIDTH-1:0]    w_owner_data;
    logic [c_OW-1:0]     w_pick_start;
    logic                w_pick_found;
    logic [c_OW-1:0]     w_pick_idx;

    assign w_owner_inc  = (r_owner == c_LAST_IDX) ? '0 : r_owner + c_OW'(1);
    assign w_cnt_inc    = r_cnt + c_CNT_ONE;
    assign w_owner_data = wdata[int'(r_owner)*WIDTH +: WIDTH];

    // While owning, arbitration starts just past the owner so it ranks last.
    assign w_pick_start = (r_state == OWN) ? w_owner_inc : r_rr;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (c_OW)
    ) u_rr_pick (
        .i_req   (req),
        .i_start (w_pick_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_q_nxt     = r_q;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;

        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_found) begin
                    w_state_nxt            = OWN;
                    w_gnt_nxt[w_pick_idx]  = 1'b1;
                    w_owner_nxt            = w_pick_idx;
                    w_cnt_nxt              = '0;
                end
            end
            OWN: begin
                if (req[r_owner]) begin
                    w_q_nxt            = w_owner_data;
                    w_ack_nxt[r_owner] = 1'b1;
                    w_cnt_nxt          = w_cnt_inc;
                end
                if (!req[r_owner] || (w_cnt_inc == c_MAX_CNT)) begin
                    w_rr_nxt  = w_owner_inc;
                    w_cnt_nxt = '0;
                    w_gnt_nxt = '0;
                    if (w_pick_found) begin
                        w_gnt_nxt[w_pick_idx] = 1'b1;
                        w_owner_nxt           = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_q     <= w_q_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign q     = r_q;
    assign owner = r_owner;
    assign busy  = (r_state == OWN);

endmodule

`default_nettype wire

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Shares one WIDTH-bit data register among NUM_REQ requesters using round-robin ownership.
- A granted requester owns the register for a bounded burst of writes, up to MAX_BURST, while it holds its request.
- Each accepted write is acknowledged with a one-cycle ack. The register value is visible on q.
- Sits in front of the team's 4-bit register datapath as its sequencer/arbiter.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- WIDTH, 4, register data width.
- MAX_BURST, 3, maximum writes per ownership (≥1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request per requester; level, held while requester wants writes.
- wdata  input  NUM_REQ*WIDTH  write data; requester i at bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- ack  output  NUM_REQ  registered one-hot pulse; high in the cycle q first shows that requester's written value.
- q  output  WIDTH  shared register contents.
- owner  output  $clog2(NUM_REQ)  index of current or last owner.
- busy  output  1  high while in OWN state.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - Outputs: q=0, gnt=0, ack=0, owner=0, busy=0.
  - Internal: state=IDLE, rr pointer=0, burst count=0.
  - A reset mid-burst aborts the burst: no partial write, and q is cleared.
- States: IDLE, OWN.
- IDLE:
  - If any req bit is set, the winner is the first set bit scanning upward from the rr pointer, with wrap.
  - At the edge: gnt=onehot(winner), owner=winner, count=0, state→OWN.
  - No req: remain IDLE with gnt=0.
- OWN, each edge:
  - If req[owner]=1:
    - q<=wdata[owner], ack[owner]<=1, count+1.
    - If count+1==MAX_BURST, release.
  - If req[owner]=0: release with no write; ack stays 0.
  - ack is 0 in every cycle with no write.
- Release, same edge:
  - rr pointer<=owner+1 (mod NUM_REQ).
  - Re-arbitrate over current req starting at owner+1, so the old owner has lowest priority.
  - Winner found: gnt/owner switch to it, count=0, stay OWN. No bubble cycle.
  - None: gnt=0, state→IDLE; owner keeps its last value.
- A lone requester holding req past MAX_BURST is regranted to itself at the release edge. Its writes and acks continue every cycle, and its count restarts.
- Latency:
  - req rises in IDLE at cycle 0.
  - gnt visible after edge 1.
  - First write at edge 2: q and ack valid in cycle 2.
  - Subsequent writes: one per cycle.
- Requests from non-owners are ignored until release; a request is never lost while held.
- wdata of non-owners is ignored. A requester must hold wdata valid while gnt is high.
- busy=1 exactly when state=OWN.
- Burst counter width is $clog2(MAX_BURST+1) and never exceeds MAX_BURST.

Decomposition:
- Package shared_reg_pkg:
  - State enum {IDLE, OWN}.
  - Default NUM_REQ/WIDTH/MAX_BURST constants.
- Sub-module rr_pick:
  - Combinational round-robin picker: req vector + start index → found flag + index.
  - Instantiated once and used for both IDLE arbitration and release re-arbitration.
- The top module holds the FSM, burst counter, rr pointer and the q register.

Test Plan:
- Reset: drive random req/wdata and assert rst_n low mid-burst → q=0, gnt=0, ack=0, busy=0 immediately, with no clock edge needed.
- Single requester: req[2]=1 for 2 writes, wdata[2]=0x3 then 0x7 → gnt=4'b0100 after edge 1; q=0x3 with ack[2] after edge 2; q=0x7 after edge 3; req drops → IDLE, gnt=0.
- Full contention: all req held, requester i drives 0xA+i, MAX_BURST=3:
  - Owners run 0,1,2,3,0, three writes each.
  - q reads 0xA×3, 0xB×3, 0xC×3, 0xD×3, then 0xA.
  - Exactly one ack per cycle, no idle gaps.
- Lone long requester: req[1] held 8 cycles with wdata 0xE → continuous acks; owner stays 1; count restarts at 3 and 6; q=0xE.
- Early drop: owner 0 drops req after 1 write while req[3] is pending → no write in the drop cycle, gnt switches to 4'b1000 at the same edge, and writes from 3 follow.
- Wrap priority: owner 3 releases with req[0] and req[2] pending → requester 0 is granted next, then 2.
